// File: rtl/fmlbrg_linemem.sv
// Byte-lane dual-port line memory with a fill/evict burst engine for the FML bridge cache.
// Reads: one cycle from the registered address. Fill: one beat per fill_strobe. Evict: one beat per cycle.
// The engine cannot be stalled. A fill beat takes priority over port A, and the port A write is dropped (wr_collide).
module fmlbrg_linemem #(
    parameter int depth = 8,
    parameter int lanes = 2,
    parameter int burst = 4
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic [depth-1:0]                 a,
    input  logic [lanes-1:0]                 we,
    input  logic [8*lanes-1:0]               di,
    output logic [8*lanes-1:0]               dout,
    input  logic [depth-1:0]                 a2,
    output logic [8*lanes-1:0]               do2,
    input  logic                             fill_start,
    input  logic                             evict_start,
    input  logic [depth-$clog2(burst)-1:0]   line,
    input  logic                             fill_strobe,
    input  logic [8*lanes-1:0]               fill_di,
    output logic                             fill_done,
    output logic                             evict_valid,
    output logic                             evict_last,
    output logic                             busy,
    output logic                             wr_collide
);
    localparam int BW = $clog2(burst);
    localparam int LW = depth - BW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(burst - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_EVICT} state_t;

    state_t           r_state;
    logic [BW-1:0]    r_beat;
    logic [LW-1:0]    r_fill_line;
    logic [LW-1:0]    r_evict_line;
    logic [depth-1:0] r_a;
    logic [depth-1:0] r_a2;
    logic             r_fill_done;
    logic             r_evict_valid;
    logic             r_evict_last;
    logic             r_wr_collide;

    logic             w_fill_we;
    logic [depth-1:0] w_fill_addr;
    logic             w_busy;

    assign w_fill_we   = (r_state == S_FILL) && fill_strobe;
    assign w_fill_addr = {r_fill_line, r_beat};
    // The last evict beat is still on do2 after the FSM returns to IDLE, so busy covers it too.
    assign w_busy      = (r_state != S_IDLE) || r_evict_valid;

    assign fill_done   = r_fill_done;
    assign evict_valid = r_evict_valid;
    assign evict_last  = r_evict_last;
    assign wr_collide  = r_wr_collide;
    assign busy        = w_busy;

    // Engine FSM, registered read addresses and registered status outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_beat        <= '0;
            r_fill_line   <= '0;
            r_evict_line  <= '0;
            r_a           <= '0;
            r_a2          <= '0;
            r_fill_done   <= 1'b0;
            r_evict_valid <= 1'b0;
            r_evict_last  <= 1'b0;
            r_wr_collide  <= 1'b0;
        end else begin
            r_a           <= a;
            r_a2          <= (r_state == S_EVICT) ? {r_evict_line, r_beat} : a2;
            r_fill_done   <= 1'b0;
            r_evict_valid <= (r_state == S_EVICT);
            r_evict_last  <= (r_state == S_EVICT) && (r_beat == LAST_BEAT);
            r_wr_collide  <= w_fill_we && (|we);
            case (r_state)
                S_IDLE: begin
                    // Fill has priority; a simultaneous evict start is dropped.
                    if (!w_busy && fill_start) begin
                        r_state     <= S_FILL;
                        r_beat      <= '0;
                        r_fill_line <= line;
                    end else if (!w_busy && evict_start) begin
                        r_state      <= S_EVICT;
                        r_beat       <= '0;
                        r_evict_line <= line;
                    end
                end
                S_FILL: begin
                    if (fill_strobe) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT) begin
                            r_state     <= S_IDLE;
                            r_fill_done <= 1'b1;
                        end
                    end
                end
                S_EVICT: begin
                    r_beat <= r_beat + 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One 8-bit RAM per byte lane. Reading from the registered address makes the read write-first per lane.
    for (genvar i = 0; i < lanes; i++) begin : g_lane
        logic [7:0] r_mem [0:(1<<depth)-1];

        // A fill beat owns the write port; otherwise port A writes this lane when its enable is set.
        always_ff @(posedge sys_clk) begin
            if (w_fill_we) begin
                r_mem[w_fill_addr] <= fill_di[8*i +: 8];
            end else if (we[i]) begin
                r_mem[a] <= di[8*i +: 8];
            end
        end

        assign dout[8*i +: 8] = r_mem[r_a];
        assign do2[8*i +: 8]  = r_mem[r_a2];
    end
endmodule

// File: tb/tb_fmlbrg_linemem.sv
// Scoreboard bench for fmlbrg_linemem: stimulus queues the expected responses and a negedge monitor checks them.
module tb_fmlbrg_linemem;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  a = '0;
    logic [1:0]  we = '0;
    logic [15:0] di = '0;
    logic [15:0] dout;
    logic [7:0]  a2 = '0;
    logic [15:0] do2;
    logic        fill_start = 1'b0;
    logic        evict_start = 1'b0;
    logic [5:0]  line = '0;
    logic        fill_strobe = 1'b0;
    logic [15:0] fill_di = '0;
    logic        fill_done;
    logic        evict_valid;
    logic        evict_last;
    logic        busy;
    logic        wr_collide;

    fmlbrg_linemem #(.depth(8), .lanes(2), .burst(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .a(a), .we(we), .di(di), .dout(dout),
        .a2(a2), .do2(do2),
        .fill_start(fill_start), .evict_start(evict_start), .line(line),
        .fill_strobe(fill_strobe), .fill_di(fill_di),
        .fill_done(fill_done), .evict_valid(evict_valid), .evict_last(evict_last),
        .busy(busy), .wr_collide(wr_collide)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] d;
        logic        last;
    } ev_t;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    ev_t         qev[$];
    logic        chk_a = 1'b0;
    logic        chk_b = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cnt_fill_done = 0;
    int          cnt_evict = 0;
    int          cnt_collide = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares outputs whenever the DUT presents them.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (chk_a) begin
                if (qa.size() == 0) check("dout_queue_empty", 1, 0);
                else check("dout", dout, qa.pop_front());
            end
            if (chk_b) begin
                if (qb.size() == 0) check("do2_queue_empty", 1, 0);
                else check("do2", do2, qb.pop_front());
            end
            if (evict_valid) begin
                ev_t e;
                cnt_evict++;
                if (qev.size() == 0) check("unexpected_evict_valid", 1, 0);
                else begin
                    e = qev.pop_front();
                    check("evict_do2", do2, e.d);
                    check("evict_last", evict_last, e.last);
                end
            end
            if (fill_done) cnt_fill_done++;
            if (wr_collide) cnt_collide++;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr_a(input logic [7:0] addr, input logic [1:0] en, input logic [15:0] d);
        a = addr; we = en; di = d;
        tick();
        we = '0;
    endtask

    task automatic rd_a(input logic [7:0] addr, input logic [15:0] exp);
        a = addr;
        tick();
        qa.push_back(exp);
        chk_a = 1'b1;
        tick();
        chk_a = 1'b0;
    endtask

    task automatic push_ev(input logic [15:0] d, input logic last);
        ev_t e;
        e.d = d;
        e.last = last;
        qev.push_back(e);
    endtask

    // Issues four fill strobes back-to-back with data base..base+3.
    task automatic fill4(input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            fill_strobe = 1'b1;
            fill_di = base + 16'(k);
            tick();
        end
        fill_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_evict_valid", evict_valid, 0);
        check("rst_evict_last", evict_last, 0);
        check("rst_wr_collide", wr_collide, 0);
        sys_rst = 1'b0;
        tick();

        // Port A write / readback with per-lane enables
        wr_a(8'd5, 2'b11, 16'hA55A);
        rd_a(8'd5, 16'hA55A);
        wr_a(8'd5, 2'b01, 16'h1234);
        qa.push_back(16'hA534);
        chk_a = 1'b1;
        tick();
        chk_a = 1'b0;

        // Write-first on port B
        a = 8'd7; we = 2'b11; di = 16'hBEEF; a2 = 8'd7;
        tick();
        we = '0;
        qb.push_back(16'hBEEF);
        chk_b = 1'b1;
        tick();
        chk_b = 1'b0;

        // Fill line 2 with gaps
        line = 6'd2; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("fill_busy_start", busy, 1);
        fill_strobe = 1'b1; fill_di = 16'h0001; tick();
        fill_di = 16'h0002; tick();
        fill_strobe = 1'b0; tick();
        check("fill_busy_gap", busy, 1);
        fill_strobe = 1'b1; fill_di = 16'h0003; tick();
        check("fill_done_early", fill_done, 0);
        fill_di = 16'h0004; tick();
        fill_strobe = 1'b0;
        check("fill_done_pulse", fill_done, 1);
        check("fill_busy_end", busy, 0);
        tick();
        check("fill_done_single", fill_done, 0);
        for (int k = 0; k < 4; k++) rd_a(8'(8 + k), 16'(k + 1));

        // Evict line 3 with a port A write to word 15 during the evict
        for (int k = 0; k < 4; k++) wr_a(8'(12 + k), 2'b11, 16'(16'hC0 + k));
        line = 6'd3; evict_start = 1'b1;
        push_ev(16'h00C0, 1'b0);
        push_ev(16'h00C1, 1'b0);
        push_ev(16'h00C2, 1'b0);
        push_ev(16'h5A5A, 1'b1);
        tick();
        evict_start = 1'b0;
        check("evict_busy_start", busy, 1);
        wr_a(8'd15, 2'b11, 16'h5A5A);
        repeat (3) tick();
        check("evict_busy_last", busy, 1);
        tick();
        check("evict_valid_drop", evict_valid, 0);
        check("evict_busy_end", busy, 0);
        check("evict_queue_drained", qev.size(), 0);

        // Fill beat collides with a port A write to the same word
        line = 6'd0; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        fill_strobe = 1'b1; fill_di = 16'h1111;
        a = 8'd0; we = 2'b11; di = 16'h2222;
        tick();
        we = '0;
        check("collide_pulse", wr_collide, 1);
        fill_di = 16'h1112; tick();
        check("collide_single", wr_collide, 0);
        fill_di = 16'h1113; tick();
        fill_di = 16'h1114; tick();
        fill_strobe = 1'b0;
        rd_a(8'd0, 16'h1111);
        rd_a(8'd3, 16'h1114);

        // Simultaneous starts: fill wins, evict dropped
        line = 6'd1; fill_start = 1'b1; evict_start = 1'b1;
        tick();
        fill_start = 1'b0; evict_start = 1'b0;
        check("both_busy", busy, 1);
        fill4(16'h2000);
        check("both_idle", busy, 0);
        repeat (3) tick();
        rd_a(8'd4, 16'h2000);
        rd_a(8'd7, 16'h2003);

        // Reset mid-evict after two beats
        line = 6'd2; evict_start = 1'b1;
        push_ev(16'h0001, 1'b0);
        push_ev(16'h0002, 1'b0);
        tick();
        evict_start = 1'b0;
        tick();
        tick();
        @(negedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check("rst_mid_evict_valid", evict_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_queue", qev.size(), 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        tick();
        line = 6'd3; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("post_rst_fill_busy", busy, 1);
        fill4(16'h3000);
        check("post_rst_fill_done", fill_done, 1);
        tick();
        rd_a(8'd12, 16'h3000);
        rd_a(8'd15, 16'h3003);

        // Totals seen by the monitor
        check("total_fill_done", cnt_fill_done, 4);
        check("total_evict_beats", cnt_evict, 6);
        check("total_collide", cnt_collide, 1);
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
